// File: rtl/carry_select_seq_ctrl.sv
// rtl/carry_select_seq_ctrl.sv - sequential slice-at-a-time adder built on one carry-select slice
// Optional subtract mode: define CARRY_SELECT_SEQ_SUB_EN to add port sub.

`ifndef BLOCK_LEN
`define BLOCK_LEN 4
`endif

module carry_select_carry_base #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] sum0;
  logic [WIDTH:0] sum1;

  // Both carry-in outcomes are formed up front; cin only steers the mux.
  assign sum0 = {1'b0, a} + {1'b0, b};
  assign sum1 = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, 1'b1};
  assign {cout, sum} = cin ? sum1 : sum0;
endmodule

module carry_select_seq_ctrl #(
  parameter int BLOCK_LEN  = `BLOCK_LEN,
  parameter int NUM_BLOCKS = 4,
  localparam int W         = BLOCK_LEN * NUM_BLOCKS,
  localparam int CNT_W     = (NUM_BLOCKS > 2) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef CARRY_SELECT_SEQ_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
`ifdef CARRY_SELECT_SEQ_SUB_EN
  logic               sub_q, sub_d;
`endif

  logic [BLOCK_LEN-1:0] slice_a;
  logic [BLOCK_LEN-1:0] slice_b;
  logic [BLOCK_LEN-1:0] slice_sum;
  logic                 slice_cout;

  assign slice_a = a_q[cnt_q*BLOCK_LEN +: BLOCK_LEN];
`ifdef CARRY_SELECT_SEQ_SUB_EN
  assign slice_b = b_q[cnt_q*BLOCK_LEN +: BLOCK_LEN] ^ {BLOCK_LEN{sub_q}};
`else
  assign slice_b = b_q[cnt_q*BLOCK_LEN +: BLOCK_LEN];
`endif

  carry_select_carry_base #(
    .WIDTH(BLOCK_LEN)
  ) u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_q),
    .sum (slice_sum),
    .cout(slice_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef CARRY_SELECT_SEQ_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
`ifdef CARRY_SELECT_SEQ_SUB_EN
          sub_d   = sub;
          // Two's-complement subtract: ~b plus an injected 1, cin unused.
          carry_d = sub ? 1'b1 : cin;
`else
          carry_d = cin;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[cnt_q*BLOCK_LEN +: BLOCK_LEN] = slice_sum;
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NUM_BLOCKS - 1)) begin
          cout_d  = slice_cout;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CARRY_SELECT_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef CARRY_SELECT_SEQ_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_carry_select_seq_ctrl.sv
// tb/tb_carry_select_seq_ctrl.sv - table-driven scoreboard bench for carry_select_seq_ctrl
// Subtract vectors are exercised only when CARRY_SELECT_SEQ_SUB_EN is defined.

module tb_carry_select_seq_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         cin_i = 1'b0;
`ifdef CARRY_SELECT_SEQ_SUB_EN
  logic         sub_i = 1'b0;
`endif
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  carry_select_seq_ctrl #(
    .BLOCK_LEN (4),
    .NUM_BLOCKS(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a_i),
    .b        (b_i),
    .cin      (cin_i),
`ifdef CARRY_SELECT_SEQ_SUB_EN
    .sub      (sub_i),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    int           hold;
    bit           keep_valid;
  } vec_t;

  vec_t         tbl[$];
  logic [W:0]   exp_q[$];
  int           total = 0;
  int           bad = 0;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                              input logic sub, input logic [W-1:0] es, input logic ec,
                              input int hold, input bit keep);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub;
    v.exp_sum = es; v.exp_cout = ec; v.hold = hold; v.keep_valid = keep;
    return v;
  endfunction

  task automatic do_txn(input vec_t v);
    int lat;
    logic [W:0] exp;
    @(posedge clk); #1;
    a_i = v.a; b_i = v.b; cin_i = v.cin;
`ifdef CARRY_SELECT_SEQ_SUB_EN
    sub_i = v.sub;
`endif
    in_valid = 1'b1;
    check("idle_in_ready", {{W{1'b0}}, in_ready}, 1);
    @(posedge clk); #1;
    exp_q.push_back({v.exp_cout, v.exp_sum});
    if (v.keep_valid) begin
      a_i = ~v.a; b_i = v.b ^ 16'h5A5A; cin_i = ~v.cin;
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (v.keep_valid) check("run_in_ready_low", {{W{1'b0}}, in_ready}, 0);
      check("run_busy", {{W{1'b0}}, busy}, 1);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("latency", (W+1)'(lat), 4);
    exp = exp_q.pop_front();
    check("result", {cout, sum}, exp);
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {{W{1'b0}}, out_valid}, 1);
      check("hold_result", {cout, sum}, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("back_idle_ready", {{W{1'b0}}, in_ready}, 1);
    check("back_idle_valid", {{W{1'b0}}, out_valid}, 0);
    check("kept_result", {cout, sum}, exp);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   m;

    tbl.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b0));
    tbl.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 1'b0));
    tbl.push_back(mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1, 1'b0));
    tbl.push_back(mk(16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      m = model(ra, rb, rc, 1'b0);
      tbl.push_back(mk(ra, rb, rc, 1'b0, m[W-1:0], m[W], 0, 1'b0));
    end
`ifdef CARRY_SELECT_SEQ_SUB_EN
    tbl.push_back(mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 0, 1'b0));
    tbl.push_back(mk(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 0, 1'b0));
    ra = W'($urandom); rb = W'($urandom);
    m = model(ra, rb, 1'b0, 1'b1);
    tbl.push_back(mk(ra, rb, 1'b0, 1'b1, m[W-1:0], m[W], 0, 1'b0));
`endif
    tbl.push_back(mk(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 3, 1'b1));

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {{W{1'b0}}, in_ready}, 1);
    check("rst_out_valid", {{W{1'b0}}, out_valid}, 0);
    check("rst_busy", {{W{1'b0}}, busy}, 0);
    check("rst_result", {cout, sum}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) do_txn(tbl[i]);

    // Abort mid-RUN: the async reset must clear everything at once.
    @(posedge clk); #1;
    a_i = 16'hABCD; b_i = 16'h1111; cin_i = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {{W{1'b0}}, out_valid}, 0);
    check("abort_sum", {{W{1'b0}}, sum}, 0);
    check("abort_busy", {{W{1'b0}}, busy}, 0);
    check("abort_in_ready", {{W{1'b0}}, in_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(mk(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 0, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
